// File: rtl/ifmp1_arb_pkg.sv
// ----------------------------------------------------------------------------
// ifmp1_arb_pkg
//   Shared types and helpers for the ifmp1 round-robin arbiter.
//   - state_e   : arbiter FSM states (IDLE, GRANT, ACKED)
//   - DefaultDw : default width of the sig1 data path
//   - rr_next   : round-robin pointer advance with explicit wrap, so that
//                 non-power-of-two requester counts wrap correctly
// ----------------------------------------------------------------------------
package ifmp1_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACKED = 2'd2
    } state_e;

    localparam int unsigned DefaultDw = 32;

    // Index following ptr, wrapping to 0 at nreq (never relies on overflow).
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned nreq);
        if (ptr + 1 >= nreq) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/ifmp1_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// ifmp1_rr_arbiter_rr_pick
//   Combinational round-robin winner selection: the first requesting index at
//   or after ptr, wrapping modulo NREQ.
//   Implemented as a double-width masked priority encoder: {req, req} with the
//   low copy masked below ptr; the lowest set bit of that vector is the winner.
//
// Ports
//   req    in   NREQ  request vector
//   ptr    in   PW    round-robin start index (0..NREQ-1)
//   win    out  PW    winning index (0 when valid=0)
//   valid  out  1     at least one request present
// ----------------------------------------------------------------------------
module ifmp1_rr_arbiter_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   win,
    output logic            valid
);

    logic [2*NREQ-1:0] ext;

    always_comb begin
        ext = {req, req};
        // Lower copy only holds indices >= ptr; upper copy supplies the wrap.
        for (int i = 0; i < NREQ; i++) begin
            if (i < 32'(ptr)) begin
                ext[i] = 1'b0;
            end
        end

        win   = '0;
        valid = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int j = 2 * NREQ - 1; j >= 0; j--) begin
            if (ext[j]) begin
                valid = 1'b1;
                if (j >= NREQ) begin
                    win = PW'(j - NREQ);
                end else begin
                    win = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ifmp1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ifmp1_rr_arbiter
//   Shares one ifmp1 channel (master drives sig1 data, slave acknowledges on
//   sig2) among NREQ requesters with round-robin arbitration. A grant is held
//   until the slave acknowledges; each transfer then spends one ACKED cycle
//   and one IDLE cycle before the next grant (3 cycles minimum per transfer).
//
// Configuration
//   IFMP1_ARB_TIMEOUT_EN : when defined, a transfer waiting TIMEOUT GRANT
//                          cycles without ack is aborted with a timeout_err
//                          pulse. When undefined, GRANT waits indefinitely
//                          and timeout_err stays 0.
//
// Ports
//   clk          in   1        clock, rising edge
//   rst_n        in   1        synchronous active-low reset
//   req          in   NREQ     request per requester, held until done[i]
//   req_data     in   NREQ*DW  flat data, requester i at [i*DW +: DW]
//   gnt          out  NREQ     one-hot grant (registered)
//   done         out  NREQ     1-cycle pulse when requester i is acknowledged
//   m_sig1       out  DW       registered data of the granted requester
//   m_valid      out  1        transfer in flight toward the slave
//   m_sig2       in   1        slave acknowledge, only honoured while m_valid
//   busy         out  1        FSM not in IDLE
//   timeout_err  out  1        1-cycle pulse on timeout abort
// ----------------------------------------------------------------------------
module ifmp1_rr_arbiter
    import ifmp1_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = DefaultDw,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [DW-1:0]     m_sig1,
    output logic              m_valid,
    input  logic              m_sig2,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_param_check
        $error("ifmp1_rr_arbiter: NREQ must be 2..16 and TIMEOUT at least 1");
    end

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_q;

    logic [PW-1:0]   pick_win;
    logic            pick_valid;
    logic [NREQ-1:0] pick_oh;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   sel_idx;
    logic [DW-1:0]   sel_data;
    logic            tmo_hit;
    logic            end_xfer;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    ifmp1_rr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign pick_oh = NREQ'(1) << pick_win;
    assign win_oh  = NREQ'(1) << win_q;

    // ------------------------------------------------------------------
    // Data mux: the fresh winner while loading a grant, else the held one
    // ------------------------------------------------------------------
    always_comb begin
        sel_idx  = (state_q == IDLE) ? pick_win : win_q;
        sel_data = req_data[32'(sel_idx) * DW +: DW];
    end

    // ------------------------------------------------------------------
    // Optional ack-wait timeout
    // ------------------------------------------------------------------
`ifdef IFMP1_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] tmo_cnt_q;

    // Count value k means k+1 GRANT cycles have elapsed in the current one.
    assign tmo_hit = (state_q == GRANT) && (tmo_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != GRANT) begin
            tmo_cnt_q <= '0;
        end else if (!m_sig2) begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // m_valid is always 1 in GRANT, so an ack there is always honoured; an ack
    // during IDLE/ACKED (including the cycle the grant loads) is never looked at.
    assign end_xfer = (m_sig2 && m_valid) || tmo_hit;

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            gnt         <= '0;
            done        <= '0;
            m_sig1      <= '0;
            m_valid     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done        <= '0;
            timeout_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        win_q   <= pick_win;
                        gnt     <= pick_oh;
                        m_valid <= 1'b1;
                        m_sig1  <= sel_data;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    m_sig1 <= sel_data;
                    if (end_xfer) begin
                        gnt     <= '0;
                        m_valid <= 1'b0;
                        m_sig1  <= '0;
                        ptr_q   <= PW'(rr_next(32'(win_q), NREQ));
                        state_q <= ACKED;
                        // Ack beats a simultaneous terminal count.
                        if (m_sig2) begin
                            done <= win_oh;
                        end else begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                ACKED: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ifmp1_rr_arbiter.sv
// Directed bench for ifmp1_rr_arbiter (NREQ=4, DW=32, TIMEOUT=8).
module tb_ifmp1_rr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [DW-1:0]     m_sig1;
    logic              m_valid;
    logic              m_sig2;
    logic              busy;
    logic              timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ifmp1_rr_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .m_sig1      (m_sig1),
        .m_valid     (m_valid),
        .m_sig2      (m_sig2),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [31:0] val);
        req_data[idx*DW +: DW] = val;
    endtask

    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_oh;
    logic       seen_bad;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        m_sig2   = 1'b0;
        seen_bad = 1'b0;

        // 1. Reset 3 cycles
        repeat (3) step();
        check("rst_gnt_done", 32'({gnt, done}), 32'h0);
        check("rst_flags", 32'({m_valid, busy, timeout_err}), 32'h0);
        check("rst_sig1", m_sig1, 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_no_req", 32'({gnt, m_valid, busy}), 32'h0);

        // 3. All requesting, immediate ack: 0,1,2,3,0 spaced 3 cycles
        for (int i = 0; i < 4; i++) set_data(i, 32'hA000_0000 + 32'(i));
        req    = 4'b1111;
        m_sig2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << order[k];
            step();
            check("rr_gnt", 32'(gnt), 32'(exp_oh));
            check("rr_sig1", m_sig1, 32'hA000_0000 + 32'(order[k]));
            step();
            check("rr_done", 32'({done, gnt, m_valid}), 32'({exp_oh, 4'b0000, 1'b0}));
            if (k == 4) begin
                req    = '0;
                m_sig2 = 1'b0;
            end
            step();
            check("rr_idle", 32'({done, gnt, busy}), 32'h0);
        end

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // 2. Single requester 2, ack two cycles after m_valid
        set_data(2, 32'hDEAD_BEEF);
        req = 4'b0100;
        step();
        check("t2_gnt", 32'({gnt, m_valid, busy}), 32'({4'b0100, 1'b1, 1'b1}));
        check("t2_sig1", m_sig1, 32'hDEAD_BEEF);
        set_data(2, 32'hCAFE_F00D);
        step();
        check("t2_track", m_sig1, 32'hCAFE_F00D);
        check("t2_hold", 32'({gnt, done}), 32'({4'b0100, 4'b0000}));
        m_sig2 = 1'b1;
        step();
        check("t2_done", 32'({done, gnt, m_valid, busy}), 32'({4'b0100, 4'b0000, 1'b0, 1'b1}));
        req    = '0;
        m_sig2 = 1'b0;
        step();
        check("t2_idle", 32'({done, busy}), 32'h0);

        // 4. ptr=3, req=0011: wrap to 0, then 1
        set_data(0, 32'h1111_0000);
        set_data(1, 32'h2222_0001);
        req    = 4'b0011;
        m_sig2 = 1'b1;
        step();
        check("t4_gnt0", 32'(gnt), 32'h1);
        check("t4_sig1_0", m_sig1, 32'h1111_0000);
        step();
        check("t4_done0", 32'(done), 32'h1);
        req = 4'b0010;
        step();
        step();
        check("t4_gnt1", 32'(gnt), 32'h2);
        check("t4_sig1_1", m_sig1, 32'h2222_0001);
        step();
        check("t4_done1", 32'(done), 32'h2);
        req    = '0;
        m_sig2 = 1'b0;
        step();

        // 5. Reset during GRANT (ptr=2, requester 3 wins first)
        req = 4'b1000;
        step();
        check("t5_gnt", 32'({gnt, m_valid}), 32'({4'b1000, 1'b1}));
        rst_n = 1'b0;
        step();
        check("t5_rst", 32'({gnt, done, m_valid, busy}), 32'h0);
        rst_n  = 1'b1;
        req    = 4'b1001;
        m_sig2 = 1'b1;
        step();
        check("t5_ptr0", 32'(gnt), 32'h1);
        step();
        check("t5_done", 32'(done), 32'h1);
        req    = '0;
        m_sig2 = 1'b0;
        step();

        // 6. No ack (ptr=1, requesters 1 and 2 waiting)
        req = 4'b0110;
        step();
        check("t6_gnt", 32'(gnt), 32'h2);
`ifdef IFMP1_ARB_TIMEOUT_EN
        repeat (7) step();
        check("t6_hold8", 32'({gnt, timeout_err}), 32'({4'b0010, 1'b0}));
        step();
        check("t6_tmo", 32'({timeout_err, done, gnt, m_valid}), 32'({1'b1, 4'b0, 4'b0, 1'b0}));
        step();
        check("t6_tmo_pulse", 32'(timeout_err), 32'h0);
        step();
        check("t6_next", 32'(gnt), 32'h4);
        m_sig2 = 1'b1;
        step();
        check("t6_next_done", 32'(done), 32'h4);
`else
        for (int c = 2; c <= 1000; c++) begin
            step();
            if (timeout_err !== 1'b0 || gnt !== 4'b0010) seen_bad = 1'b1;
        end
        check("t6_hold1000", 32'({gnt, m_valid, seen_bad}), 32'({4'b0010, 1'b1, 1'b0}));
        m_sig2 = 1'b1;
        step();
        check("t6_late_done", 32'({done, timeout_err}), 32'({4'b0010, 1'b0}));
`endif
        req    = '0;
        m_sig2 = 1'b0;
        step();
        step();
        check("final_idle", 32'({busy, gnt}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
